// File: rtl/tipi_sync_regbank_if.sv
// TI bus and RPi serial-link bundle for the tipi_sync_regbank mailbox.
// The slave modport is the register bank; the master modport is the bus side driving it.
interface tipi_sync_regbank_if #(
    parameter int NUM_CH = 2,
    parameter int SEL_W  = 2
);
    logic              cru_dsr_en;
    logic [0:15]       ti_a;
    logic [0:7]        ti_data;
    logic              ti_memen;
    logic              ti_we;
    logic              ti_dbin;
    logic              rd_hit;
    logic [0:7]        rd_data;
    logic              rpi_sclk;
    logic              rpi_sle;
    logic [SEL_W-1:0]  rpi_regsel;
    logic              rpi_sdata_out;
    logic              rpi_sdata_in;
    logic [NUM_CH-1:0] to_ti_valid;
    logic [NUM_CH-1:0] from_ti_valid;
    logic [NUM_CH-1:0] from_ti_ovr;

    modport slave (
        input  cru_dsr_en, ti_a, ti_data, ti_memen, ti_we, ti_dbin,
        input  rpi_sclk, rpi_sle, rpi_regsel, rpi_sdata_out,
        output rd_hit, rd_data, rpi_sdata_in,
        output to_ti_valid, from_ti_valid, from_ti_ovr
    );

    modport master (
        output cru_dsr_en, ti_a, ti_data, ti_memen, ti_we, ti_dbin,
        output rpi_sclk, rpi_sle, rpi_regsel, rpi_sdata_out,
        input  rd_hit, rd_data, rpi_sdata_in,
        input  to_ti_valid, from_ti_valid, from_ti_ovr
    );
endinterface

// File: rtl/tipi_sync_regbank.sv
// Clocked TI<->RPi mailbox register bank with per-channel valid/overrun flags.
// Optional macro TIPI_SCLK_FILTER_EN adds a 3-clk glitch filter on synced rpi_sclk/rpi_sle.
module tipi_sync_regbank #(
    parameter int          NUM_CH      = 2,
    parameter int          SEL_W       = 2,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] REG_BASE    = 16'h5FF8
) (
    input logic                clk,
    input logic                rst_n,
    tipi_sync_regbank_if.slave bus
);
    localparam int SW = 3 + SEL_W + 2 * NUM_CH + 8;

    genvar gi;

    // Address decode on the raw TI bus; the read path must stay combinational.
    logic              ti_rd_cyc;
    logic              ti_wr_cyc;
    logic [NUM_CH-1:0] rd_match;
    logic [NUM_CH-1:0] wr_match;

    assign ti_rd_cyc = bus.cru_dsr_en & ~bus.ti_memen & bus.ti_dbin;
    assign ti_wr_cyc = bus.cru_dsr_en & ~bus.ti_memen & ~bus.ti_we;

    for (gi = 0; gi < NUM_CH; gi++) begin : g_decode
        localparam logic [15:0] TO_ADDR   = REG_BASE + 16'(1 + 2 * gi);
        localparam logic [15:0] FROM_ADDR = REG_BASE + 16'(1 + 2 * NUM_CH + 2 * gi);
        assign rd_match[gi] = ti_rd_cyc & (bus.ti_a == TO_ADDR);
        assign wr_match[gi] = ti_wr_cyc & (bus.ti_a == FROM_ADDR);
    end

    logic [SW-1:0]                   sync_raw;
    logic [SYNC_STAGES-1:0][SW-1:0]  sync_reg;
    logic                            s_sclk;
    logic                            s_sle;
    logic                            s_sdata;
    logic [SEL_W-1:0]                s_sel;
    logic [NUM_CH-1:0]               s_rd;
    logic [NUM_CH-1:0]               s_wr;
    logic [7:0]                      s_data;

    assign sync_raw = {bus.rpi_sclk, bus.rpi_sle, bus.rpi_sdata_out, bus.rpi_regsel,
                       rd_match, wr_match, bus.ti_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], sync_raw};
        end
    end

    assign {s_sclk, s_sle, s_sdata, s_sel, s_rd, s_wr, s_data} = sync_reg[SYNC_STAGES-1];

    // Index 0 is sclk, index 1 is sle.
    logic [1:0] pin_sync;
    logic [1:0] pin_rise;
    assign pin_sync = {s_sle, s_sclk};

`ifdef TIPI_SCLK_FILTER_EN
    for (gi = 0; gi < 2; gi++) begin : g_filt
        logic       filt_reg;
        logic [1:0] cnt_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                filt_reg <= 1'b0;
                cnt_reg  <= 2'd0;
            end else if (pin_sync[gi] == filt_reg) begin
                cnt_reg <= 2'd0;
            end else if (cnt_reg == 2'd2) begin
                filt_reg <= pin_sync[gi];
                cnt_reg  <= 2'd0;
            end else begin
                cnt_reg <= cnt_reg + 2'd1;
            end
        end

        // Accept on the third consecutive clk at the new level.
        assign pin_rise[gi] = pin_sync[gi] & ~filt_reg & (cnt_reg == 2'd2);
    end
`else
    logic [1:0] pin_prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_prev_reg <= 2'b00;
        end else begin
            pin_prev_reg <= pin_sync;
        end
    end

    assign pin_rise = pin_sync & ~pin_prev_reg;
`endif

    logic sclk_rise;
    logic sle_rise;
    assign sclk_rise = pin_rise[0];
    assign sle_rise  = pin_rise[1];

    logic [NUM_CH-1:0] rd_prev_reg;
    logic [NUM_CH-1:0] wr_prev_reg;
    logic [7:0]        cap_reg;
    logic [NUM_CH-1:0] rd_end;
    logic [NUM_CH-1:0] wr_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_prev_reg <= '0;
            wr_prev_reg <= '0;
            cap_reg     <= 8'h00;
        end else begin
            rd_prev_reg <= s_rd;
            wr_prev_reg <= s_wr;
            if (|s_wr) cap_reg <= s_data;
        end
    end

    assign rd_end = rd_prev_reg & ~s_rd;
    assign wr_end = wr_prev_reg & ~s_wr;

    logic [NUM_CH-1:0][7:0] to_hold_w;
    logic [NUM_CH-1:0][7:0] from_sh_w;
    logic [NUM_CH-1:0]      to_valid_w;
    logic [NUM_CH-1:0]      from_valid_w;
    logic [NUM_CH-1:0]      from_ovr_w;
    logic [NUM_CH-1:0]      from_sel_w;

    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [7:0] to_sh_reg;
        logic [7:0] to_hold_reg;
        logic       to_valid_reg;
        logic [7:0] from_sh_reg;
        logic [7:0] from_hold_reg;
        logic       from_valid_reg;
        logic       from_ovr_reg;
        logic       to_sel;
        logic       from_sel;

        assign to_sel   = (s_sel == SEL_W'(gi));
        assign from_sel = (s_sel == SEL_W'(NUM_CH + gi));

        // A same-clk RPi load beats the end of a TI read.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                to_sh_reg    <= 8'h00;
                to_hold_reg  <= 8'h00;
                to_valid_reg <= 1'b0;
            end else begin
                if (to_sel && sclk_rise) to_sh_reg <= {to_sh_reg[6:0], s_sdata};
                if (to_sel && sle_rise) begin
                    to_hold_reg  <= to_sh_reg;
                    to_valid_reg <= 1'b1;
                end else if (rd_end[gi]) begin
                    to_valid_reg <= 1'b0;
                end
            end
        end

        // A same-clk TI commit leaves valid set while the shifter takes the old byte.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                from_sh_reg    <= 8'h00;
                from_hold_reg  <= 8'h00;
                from_valid_reg <= 1'b0;
                from_ovr_reg   <= 1'b0;
            end else begin
                if (from_sel && sle_rise) begin
                    from_sh_reg <= from_hold_reg;
                end else if (from_sel && sclk_rise) begin
                    from_sh_reg <= {from_sh_reg[6:0], 1'b0};
                end
                if (wr_end[gi]) begin
                    from_hold_reg  <= cap_reg;
                    from_valid_reg <= 1'b1;
                    if (from_valid_reg) from_ovr_reg <= 1'b1;
                end else if (from_sel && sle_rise) begin
                    from_valid_reg <= 1'b0;
                end
            end
        end

        assign to_hold_w[gi]    = to_hold_reg;
        assign from_sh_w[gi]    = from_sh_reg;
        assign to_valid_w[gi]   = to_valid_reg;
        assign from_valid_w[gi] = from_valid_reg;
        assign from_ovr_w[gi]   = from_ovr_reg;
        assign from_sel_w[gi]   = from_sel;
    end

    logic [7:0] rd_mux;
    logic       sdata_in_mux;

    always_comb begin
        rd_mux = 8'h00;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_match[k]) rd_mux = to_hold_w[k];
        end
    end

    always_comb begin
        sdata_in_mux = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (from_sel_w[k]) sdata_in_mux = from_sh_w[k][7];
        end
    end

    assign bus.rd_hit        = rst_n & (|rd_match);
    assign bus.rd_data       = rd_mux;
    assign bus.rpi_sdata_in  = sdata_in_mux;
    assign bus.to_ti_valid   = to_valid_w;
    assign bus.from_ti_valid = from_valid_w;
    assign bus.from_ti_ovr   = from_ovr_w;
endmodule
